// File: rtl/tile_blitter_pkg.sv
// Shared constants and types for the tile blitter: screen geometry, draw modes,
// tile IDs shared with the datapath, and the pixel-pipe record.
package tile_blitter_pkg;

    localparam int unsigned SCREEN_W    = 320;
    localparam int unsigned SCREEN_H    = 240;
    localparam int unsigned TILE_SIZE   = 16;
    localparam logic [2:0]  TRANSPARENT = 3'b101;

    localparam int unsigned STAGE_PIXELS = SCREEN_W * SCREEN_H;

    localparam logic [3:0] TILE_HEART      = 4'd9;
    localparam logic [3:0] TILE_BOMB       = 4'd10;
    localparam logic [3:0] TILE_EXPLOSION  = 4'd11;
    localparam logic [3:0] TILE_PLAYER     = 4'd12;
    localparam logic [3:0] TILE_INVINCIBLE = 4'd14;

    typedef enum logic [1:0] {
        MODE_STAGE  = 2'd0,
        MODE_TILE   = 2'd1,
        MODE_SPRITE = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_t;

    // One in-flight pixel travelling alongside its ROM read.
    typedef struct packed {
        logic       valid;
        logic       clip;
        logic       keyed;
        logic       stage;
        logic [8:0] x;
        logic [7:0] y;
    } pix_t;

endpackage

// File: rtl/tile_blitter_if.sv
// Command, ROM and VGA-side signals of the tile blitter grouped as one bundle.
interface tile_blitter_if;

    logic        go;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [3:0]  tile_select;
    logic [1:0]  memory_select;
    logic [16:0] stage_addr;
    logic [2:0]  stage_data;
    logic [11:0] tile_addr;
    logic [2:0]  tile_data;
    logic [8:0]  X_out;
    logic [7:0]  Y_out;
    logic [2:0]  colour;
    logic        write_en;
    logic        busy;
    logic        finished;

    modport slave (
        input  go, X, Y, tile_select, memory_select, stage_data, tile_data,
        output stage_addr, tile_addr, X_out, Y_out, colour, write_en, busy, finished
    );

    modport master (
        output go, X, Y, tile_select, memory_select, stage_data, tile_data,
        input  stage_addr, tile_addr, X_out, Y_out, colour, write_en, busy, finished
    );

endinterface

// File: rtl/blit_pixel_pipe.sv
// Delay line that keeps pixel coordinates aligned with synchronous ROM data,
// plus the screen-clip and colour-key write suppression.
module blit_pixel_pipe
    import tile_blitter_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue,
    input  mode_t      mode,
    input  logic [9:0] px,
    input  logic [8:0] py,
    input  logic [2:0] stage_data,
    input  logic [2:0] tile_data,
    output logic [8:0] X_out,
    output logic [7:0] Y_out,
    output logic [2:0] colour,
    output logic       write_en
);

    pix_t entry;
    pix_t tail;
    pix_t pipe_q [ROM_LATENCY];
    logic [2:0] src;

    // Clip is decided on the full-width sums so wrap-around cannot sneak a pixel on screen.
    always_comb begin
        entry = '0;
        if (issue) begin
            entry.valid = 1'b1;
            entry.clip  = (px >= 10'(SCREEN_W)) || (py >= 9'(SCREEN_H));
            entry.keyed = (mode == MODE_SPRITE);
            entry.stage = (mode == MODE_STAGE);
            entry.x     = px[8:0];
            entry.y     = py[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= entry;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        tail     = pipe_q[ROM_LATENCY-1];
        src      = tail.stage ? stage_data : tile_data;
        X_out    = tail.x;
        Y_out    = tail.y;
        colour   = tail.valid ? src : 3'b000;
        write_en = tail.valid & ~tail.clip & ~(tail.keyed & (src == TRANSPARENT));
    end

endmodule

// File: rtl/tile_blitter.sv
// Pixel-copy engine: walks the stage or a tile ROM one address per cycle and
// streams the resulting pixels to the VGA adapter, then pulses finished.
module tile_blitter
    import tile_blitter_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 1
) (
    input logic           clock,
    input logic           reset,
    tile_blitter_if.slave bus
);

    state_t      state_q;
    mode_t       mode_q;
    mode_t       mode_in;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [3:0]  tile_q;
    logic [3:0]  tx_q;
    logic [3:0]  ty_q;
    logic [8:0]  sx_q;
    logic [7:0]  sy_q;
    logic [16:0] saddr_q;
    logic [1:0]  drain_q;
    logic        busy_q;
    logic        finished_q;
    logic        last_pixel;
    logic        issue;
    logic [9:0]  px;
    logic [8:0]  py;

    // Reserved mode 3 behaves like an opaque tile.
    always_comb begin
        unique case (bus.memory_select)
            2'd0:    mode_in = MODE_STAGE;
            2'd2:    mode_in = MODE_SPRITE;
            default: mode_in = MODE_TILE;
        endcase
    end

    always_comb begin
        if (mode_q == MODE_STAGE) begin
            last_pixel = (sx_q == 9'(SCREEN_W - 1)) && (sy_q == 8'(SCREEN_H - 1));
            px         = {1'b0, sx_q};
            py         = {1'b0, sy_q};
        end else begin
            last_pixel = (tx_q == 4'(TILE_SIZE - 1)) && (ty_q == 4'(TILE_SIZE - 1));
            px         = {1'b0, x_q} + {6'b0, tx_q};
            py         = {1'b0, y_q} + {5'b0, ty_q};
        end
        issue = (state_q == StFetch);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= MODE_STAGE;
            x_q        <= '0;
            y_q        <= '0;
            tile_q     <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            saddr_q    <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.go) begin
                        x_q     <= bus.X;
                        y_q     <= bus.Y;
                        tile_q  <= bus.tile_select;
                        mode_q  <= mode_in;
                        tx_q    <= '0;
                        ty_q    <= '0;
                        sx_q    <= '0;
                        sy_q    <= '0;
                        saddr_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (last_pixel) begin
                        drain_q <= '0;
                        state_q <= StDrain;
                    end else if (mode_q == MODE_STAGE) begin
                        // Running address avoids a sy*SCREEN_W multiplier.
                        saddr_q <= saddr_q + 17'd1;
                        if (sx_q == 9'(SCREEN_W - 1)) begin
                            sx_q <= '0;
                            sy_q <= sy_q + 8'd1;
                        end else begin
                            sx_q <= sx_q + 9'd1;
                        end
                    end else begin
                        tx_q <= tx_q + 4'd1;
                        if (tx_q == 4'(TILE_SIZE - 1)) begin
                            ty_q <= ty_q + 4'd1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == 2'(ROM_LATENCY - 1)) begin
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.stage_addr = saddr_q;
    assign bus.tile_addr  = {tile_q, ty_q, tx_q};
    assign bus.busy       = busy_q;
    assign bus.finished   = finished_q;

    blit_pixel_pipe #(
        .ROM_LATENCY(ROM_LATENCY)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .issue     (issue),
        .mode      (mode_q),
        .px        (px),
        .py        (py),
        .stage_data(bus.stage_data),
        .tile_data (bus.tile_data),
        .X_out     (bus.X_out),
        .Y_out     (bus.Y_out),
        .colour    (bus.colour),
        .write_en  (bus.write_en)
    );

endmodule
